encode_pack: RTL and testbench

Bit packer directly downstream of the LZS encode controller. Consumes the controller's variable-length code stream (`cnt_output` / `cnt_len` / `cnt_output_enable` / `cnt_finish`), concatenates codes MSB-first into 32-bit words and buffers them in a small FIFO. The FIFO presents a valid/ready word interface to the output DMA. The controller has no backpressure, so FIFO overrun is detected and flagged, not stalled.

---
 rtl/encode_pack.sv | 194 +++++++++++++++++++
 tb/tb_encode_pack.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encode_pack.sv
// encode_pack: packs variable-length LZS codes MSB-first into 32-bit words
// and buffers them in a small FIFO with a valid/ready output.
// Optional build macro: ENCODE_PACK_BSWAP_EN byte-swaps out_data for
// little-endian memory writes; packing, counts and flags are unchanged.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_RUN   | accept codes, push each completed 32-bit word
// S_FLUSH | one cycle: push the zero-padded partial word, if any
// S_DRAIN | wait for the FIFO to empty
// S_DONE  | terminal, done=1 until reset
module encode_pack #(
    parameter int FIFO_AW = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cnt_output_enable,
    input  logic [3:0]  cnt_len,
    input  logic [12:0] cnt_output,
    input  logic        cnt_finish,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] word_cnt,
    output logic        overflow,
    output logic        done
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] ONE_C   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0] ZERO_C  = '0;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [46:0] acc_q, acc_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;

    logic        code_take;
    logic [15:0] code_mask;
    logic [14:0] code_bits;
    logic [5:0]  code_shift;
    logic [5:0]  bit_sum;
    logic [46:0] acc_app;

    logic        push_req;
    logic [31:0] push_word;

    logic [31:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [FIFO_AW:0]   fifo_cnt_q;
    logic [31:0]        head_q, head_d;
    logic               pop, full, push_ok;

    // Place the masked code directly below the bits already held in acc.
    // With bit_cnt <= 31 and len <= 15 the shift is always at least 1.
    always_comb begin
        code_take  = (state_q == S_RUN) && cnt_output_enable && (cnt_len != 4'd0);
        code_mask  = (16'd1 << cnt_len) - 16'd1;
        code_bits  = {2'b00, cnt_output} & code_mask[14:0];
        code_shift = 6'd47 - bit_cnt_q - {2'b00, cnt_len};
        bit_sum    = bit_cnt_q + {2'b00, cnt_len};
        acc_app    = acc_q | ({32'd0, code_bits} << code_shift);
    end

    // State, accumulator and bit count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_RUN;
            acc_q     <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Next state, accumulator update and word push request.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        bit_cnt_d = bit_cnt_q;
        push_req  = 1'b0;
        push_word = acc_q[46:15];
        case (state_q)
            S_RUN: begin
                if (code_take) begin
                    if (bit_sum >= 6'd32) begin
                        push_req  = 1'b1;
                        push_word = acc_app[46:15];
                        acc_d     = acc_app << 32;
                        bit_cnt_d = bit_sum - 6'd32;
                    end else begin
                        acc_d     = acc_app;
                        bit_cnt_d = bit_sum;
                    end
                end
                if (cnt_finish) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (bit_cnt_q != 6'd0) begin
                    push_req  = 1'b1;
                    push_word = acc_q[46:15];
                end
                acc_d     = '0;
                bit_cnt_d = '0;
                state_d   = S_DRAIN;
            end
            S_DRAIN: begin
                if (fifo_cnt_q == ZERO_C) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    assign done      = (state_q == S_DONE);
    assign out_valid = (fifo_cnt_q != ZERO_C);

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    always_comb begin
        pop     = out_valid && out_ready;
        full    = (fifo_cnt_q == DEPTH_C);
        push_ok = push_req && (!full || pop);
        rd_nxt  = rd_ptr_q + 1'b1;
        head_d  = head_q;
        if (pop) begin
            if (fifo_cnt_q > ONE_C) begin
                head_d = mem[rd_nxt];
            end else if (push_ok) begin
                head_d = push_word;
            end
        end else if ((fifo_cnt_q == ZERO_C) && push_ok) begin
            head_d = push_word;
        end
    end

    // FIFO storage; contents need no reset since fifo_cnt gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_word;
        end
    end

    // FIFO pointers, registered head word, push counter and overrun flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            head_q     <= '0;
            word_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            head_q <= head_d;
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_nxt;
            end
            fifo_cnt_q <= fifo_cnt_q + (push_ok ? ONE_C : ZERO_C) - (pop ? ONE_C : ZERO_C);
            if (push_req) begin
                word_cnt <= word_cnt + 16'd1;
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef ENCODE_PACK_BSWAP_EN
    assign out_data = {head_q[7:0], head_q[15:8], head_q[23:16], head_q[31:24]};
`else
    assign out_data = head_q;
`endif

endmodule

// File: tb/tb_encode_pack.sv
// Scoreboard bench for encode_pack: a bit-queue reference model predicts
// each accepted word; a negedge monitor checks every output handshake.
module tb_encode_pack;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cnt_output_enable;
    logic [3:0]  cnt_len;
    logic [12:0] cnt_output;
    logic        cnt_finish;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] word_cnt;
    logic        overflow;
    logic        done;

    encode_pack #(.FIFO_AW(2)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cnt_output_enable (cnt_output_enable),
        .cnt_len           (cnt_len),
        .cnt_output        (cnt_output),
        .cnt_finish        (cnt_finish),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .word_cnt          (word_cnt),
        .overflow          (overflow),
        .done              (done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    bit          bitq[$];
    int          mcount;
    int          mphase;
    logic [15:0] mword_cnt;
    bit          movf;
    logic [31:0] last_word;
    int          words_seen;

    function automatic logic [31:0] sw(input logic [31:0] w);
`ifdef ENCODE_PACK_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] take_word();
        logic [31:0] w = '0;
        for (int i = 0; i < 32; i++) begin
            w = {w[30:0], logic'(bitq.pop_front())};
        end
        return w;
    endfunction

    // Reference model for one clock: codes become a flat bit stream, every
    // 32 bits form a word, and the FIFO is tracked only by its occupancy.
    task automatic model_cycle();
        bit          pop;
        bit          push;
        logic [31:0] w;
        logic [14:0] v15;
        pop  = (mcount > 0) && out_ready;
        push = 1'b0;
        w    = '0;
        case (mphase)
            0: begin
                if (cnt_output_enable && cnt_len != 4'd0) begin
                    v15 = {2'b00, cnt_output};
                    for (int i = int'(cnt_len) - 1; i >= 0; i--) begin
                        bitq.push_back(v15[i]);
                    end
                end
                if (bitq.size() >= 32) begin
                    push = 1'b1;
                    w    = take_word();
                end
                if (cnt_finish) mphase = 1;
            end
            1: begin
                if (bitq.size() > 0) begin
                    while (bitq.size() < 32) bitq.push_back(1'b0);
                    push = 1'b1;
                    w    = take_word();
                end
                mphase = 2;
            end
            2: begin
                if (mcount == 0) mphase = 3;
            end
            default: ;
        endcase
        if (push) begin
            mword_cnt++;
            if (mcount < DEPTH || pop) begin
                exp_q.push_back(sw(w));
                mcount++;
            end else begin
                movf = 1'b1;
            end
        end
        if (pop) mcount--;
    endtask

    task automatic cyc(input bit e, input logic [3:0] l, input logic [12:0] v, input bit f);
        cnt_output_enable = e;
        cnt_len           = l;
        cnt_output        = v;
        cnt_finish        = f;
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 13'd0, 1'b0);
    endtask

    task automatic model_clear();
        bitq.delete();
        exp_q.delete();
        mcount    = 0;
        mphase    = 0;
        mword_cnt = '0;
        movf      = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_out_data"},  out_data,         32'h0);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'h0);
        check({tag, "_word_cnt"},  {16'd0, word_cnt}, 32'h0);
        check({tag, "_overflow"},  {31'd0, overflow}, 32'h0);
        check({tag, "_done"},      {31'd0, done},     32'h0);
    endtask

    task automatic do_reset();
        cnt_output_enable = 1'b0;
        cnt_len           = '0;
        cnt_output        = '0;
        cnt_finish        = 1'b0;
        rst_n             = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_word_cnt"}, {16'd0, word_cnt}, {16'd0, mword_cnt});
        check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, movf});
        check({tag, "_done"},     {31'd0, done},     {31'd0, (mphase == 3)});
    endtask

    // Holds cnt_finish high until done, with a cycle budget.
    task automatic finish_and_wait(input string tag);
        int n;
        out_ready = 1'b1;
        n = 0;
        while (!done && n < 60) begin
            cyc(1'b0, 4'd0, 13'd0, 1'b1);
            n++;
        end
        check({tag, "_done"}, {31'd0, done}, 32'h1);
        check({tag, "_drained"}, exp_q.size(), 32'h0);
    endtask

    // Monitor: every accepted word must match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_word: got %h expected none", out_data);
            end else begin
                check("word", out_data, exp_q.pop_front());
            end
            last_word = out_data;
            words_seen++;
        end
    end

    initial begin
        int base;
        words_seen        = 0;
        last_word         = '0;
        out_ready         = 1'b1;
        cnt_output_enable = 1'b0;
        cnt_len           = '0;
        cnt_output        = '0;
        cnt_finish        = 1'b0;
        rst_n             = 1'b0;
        model_clear();
        #2;
        check_reset_vals("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // basic packing
        base = words_seen;
        for (int i = 1; i <= 8; i++) cyc(1'b1, 4'd4, 13'(i), 1'b0);
        idle(2);
        check("basic_word", last_word, sw(32'h12345678));
        check("basic_count", words_seen - base, 32'd1);
        check("basic_word_cnt", {16'd0, word_cnt}, 32'd1);

        // straddle and flush
        do_reset();
        base = words_seen;
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'd13, 13'h1FFF, 1'b0);
        finish_and_wait("straddle");
        check("straddle_count", words_seen - base, 32'd2);
        check("straddle_last", last_word, sw(32'hFE000000));
        check("straddle_word_cnt", {16'd0, word_cnt}, 32'd2);
        check("straddle_overflow", {31'd0, overflow}, 32'd0);

        // overrun with the consumer stalled
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 40; i++) cyc(1'b1, 4'd4, 13'h5, 1'b0);
        idle(1);
        check("ovr_word_cnt", {16'd0, word_cnt}, 32'd5);
        check("ovr_overflow", {31'd0, overflow}, 32'd1);
        check("ovr_valid", {31'd0, out_valid}, 32'd1);
        check("ovr_data", out_data, sw(32'h55555555));
        base = words_seen;
        out_ready = 1'b1;
        idle(10);
        check("ovr_drained", words_seen - base, 32'd4);

        // flush with nothing pending
        do_reset();
        base = words_seen;
        for (int i = 0; i < 8; i++) cyc(1'b1, 4'd4, 13'($urandom), 1'b0);
        finish_and_wait("eflush");
        check("eflush_count", words_seen - base, 32'd1);
        check("eflush_word_cnt", {16'd0, word_cnt}, 32'd1);

        // reset mid-stream
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'd9, 13'h1AB, 1'b0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 4'd4, 13'hF, 1'b0);
        rst_n = 1'b0;
        #2;
        check_reset_vals("mid_rst");
        do_reset();
        out_ready = 1'b1;
        base = words_seen;
        for (int i = 0; i < 8; i++) cyc(1'b1, 4'd4, 13'hA, 1'b0);
        idle(2);
        check("mid_rst_word", last_word, sw(32'hAAAAAAAA));
        check("mid_rst_count", words_seen - base, 32'd1);

        // randomized streams against the model
        for (int run = 0; run < 4; run++) begin
            do_reset();
            for (int i = 0; i < 300; i++) begin
                out_ready = ($urandom_range(0, 3) != 0) || (run == 0);
                if (run == 3 && i > 100 && i < 160) out_ready = 1'b0;
                cyc(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                    13'($urandom), 1'b0);
            end
            end_checks("rnd_run");
            finish_and_wait("rnd_fin");
            end_checks("rnd_end");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
